// File: rtl/muldiv_control_sequencer.sv
// Control-step sequencer for MUL/DIV: fetch T0-T2, execute T3-T6, result written to LO/HI.
// Optional T1 memory-wait timeout is enabled by defining MULDIV_SEQ_TIMEOUT_EN.
module muldiv_control_sequencer #(
  parameter logic [4:0] OPC_MUL = 5'b01111,
  parameter logic [4:0] OPC_DIV = 5'b10000,
  parameter logic [3:0] ALU_MUL = 4'd12,
  parameter logic [3:0] ALU_DIV = 4'd13
`ifdef MULDIV_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [31:0] enable,
  output logic [31:0] bus_select,
  output logic        md_read,
  output logic        inc_pc,
  output logic [3:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_T6   = 3'd7;

  logic [2:0] state, state_nxt;
  logic [3:0] rb_q;
  logic [4:0] opc_q;

  logic [4:0] opc;
  logic [3:0] ra, rb;
  logic       opc_legal;
  logic       unused_ir;

  assign opc       = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign opc_legal = (opc == OPC_MUL) || (opc == OPC_DIV);
  assign unused_ir = ^ir[18:0];

`ifdef MULDIV_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // Fires on the TIMEOUT-th consecutive T1 cycle without mem_ready.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (clr || state != S_T1) begin
      wait_cnt <= '0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      rb_q  <= '0;
      opc_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T3) begin
        rb_q  <= rb;
        opc_q <= opc;
      end
    end
  end

  // NOTE: every output and state_nxt gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    enable     = '0;
    bus_select = '0;
    md_read    = 1'b0;
    inc_pc     = 1'b0;
    alu_op     = '0;
    busy       = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    if (!clr) begin
      busy = (state != S_IDLE);
      case (state)
        S_IDLE: if (start) state_nxt = S_T0;
        S_T0: begin
          bus_select[20] = 1'b1;
          enable[25]     = 1'b1;
          enable[18]     = 1'b1;
          inc_pc         = 1'b1;
          state_nxt      = S_T1;
        end
        S_T1: begin
          bus_select[19] = 1'b1;
          enable[21]     = 1'b1;
          md_read        = 1'b1;
          // PC loads only on the exit cycle so a long wait still bumps it once.
          if (mem_ready) begin
            enable[20] = 1'b1;
            state_nxt  = S_T2;
          end
`ifdef MULDIV_SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            illegal   = 1'b1;
            state_nxt = S_IDLE;
          end
`endif
        end
        S_T2: begin
          bus_select[21] = 1'b1;
          enable[24]     = 1'b1;
          state_nxt      = S_T3;
        end
        S_T3: begin
          if (opc_legal) begin
            bus_select = 32'd1 << ra;
            enable[19] = 1'b1;
            state_nxt  = S_T4;
          end else begin
            illegal   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_T4: begin
          bus_select = 32'd1 << rb_q;
          enable[18] = 1'b1;
          alu_op     = (opc_q == OPC_MUL) ? ALU_MUL : ALU_DIV;
          state_nxt  = S_T5;
        end
        S_T5: begin
          bus_select[19] = 1'b1;
          enable[17]     = 1'b1;
          state_nxt      = S_T6;
        end
        S_T6: begin
          bus_select[18] = 1'b1;
          enable[16]     = 1'b1;
          done           = 1'b1;
          state_nxt      = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_control_sequencer.sv
// Self-checking bench for muldiv_control_sequencer: directed cases plus randomized instructions
// checked cycle by cycle against expected step records built from the instruction fields.
module tb_muldiv_control_sequencer;

  localparam logic [4:0] OPC_MUL = 5'b01111;
  localparam logic [4:0] OPC_DIV = 5'b10000;
  localparam int         TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] enable;
    logic [31:0] bus_select;
    logic        md_read;
    logic        inc_pc;
    logic [3:0]  alu_op;
    logic        busy;
    logic        done;
    logic        illegal;
  } out_t;

  logic        clk, clr, start, mem_ready;
  logic [31:0] ir;
  logic [31:0] enable, bus_select;
  logic        md_read, inc_pc, busy, done, illegal;
  logic [3:0]  alu_op;
  out_t        obs;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_control_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
    .enable(enable), .bus_select(bus_select), .md_read(md_read), .inc_pc(inc_pc),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
  );

  assign obs = {enable, bus_select, md_read, inc_pc, alu_op, busy, done, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] bit_of(input int i);
    logic [31:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic out_t busy_rec(input logic [31:0] en, input logic [31:0] bs,
                                    input logic md, input logic inc, input logic [3:0] alu,
                                    input logic dn, input logic ill);
    out_t r;
    r.enable = en; r.bus_select = bs; r.md_read = md; r.inc_pc = inc;
    r.alu_op = alu; r.busy = 1'b1; r.done = dn; r.illegal = ill;
    return r;
  endfunction

  function automatic out_t t1_rec(input logic exit_cycle, input logic ill);
    return busy_rec(bit_of(21) | (exit_cycle ? bit_of(20) : 32'd0), bit_of(19),
                    1'b1, 1'b0, 4'd0, 1'b0, ill);
  endfunction

  task automatic check(input out_t exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input out_t exp, input string tag);
    @(negedge clk);
    check(exp, tag);
    @(posedge clk);
    #1;
  endtask

  // One instruction: expected per-step records derived from ir fields and the wait count.
  task automatic run_instr(input logic [31:0] ir_v, input int waits, input bit clr_at_t4,
                           input bit start_at_end, input string tag);
    logic [4:0] opc;
    logic [3:0] ra, rb, alu;
    bit         legal;
    opc   = ir_v[31:27];
    ra    = ir_v[26:23];
    rb    = ir_v[22:19];
    legal = (opc == OPC_MUL) || (opc == OPC_DIV);
    alu   = (opc == OPC_MUL) ? 4'd12 : 4'd13;

    start = 1'b1; ir = ir_v; mem_ready = 1'($urandom_range(0, 1));
    cyc('0, {tag, ".idle_start"});
    start = 1'b0; mem_ready = 1'($urandom_range(0, 1));
    cyc(busy_rec(bit_of(25) | bit_of(18), bit_of(20), 1'b0, 1'b1, 4'd0, 1'b0, 1'b0), {tag, ".t0"});
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0; start = 1'($urandom_range(0, 1));
      cyc(t1_rec(1'b0, 1'b0), $sformatf("%s.t1_wait%0d", tag, i));
    end
    mem_ready = 1'b1; start = 1'b0;
    cyc(t1_rec(1'b1, 1'b0), {tag, ".t1_exit"});
    mem_ready = 1'($urandom_range(0, 1));
    cyc(busy_rec(bit_of(24), bit_of(21), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), {tag, ".t2"});
    if (!legal) begin
      start = start_at_end;
      cyc(busy_rec('0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1), {tag, ".t3_illegal"});
      start = 1'b0;
      cyc('0, {tag, ".after_illegal"});
      return;
    end
    cyc(busy_rec(bit_of(19), bit_of(int'(ra)), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), {tag, ".t3"});
    ir = $urandom;
    if (clr_at_t4) begin
      clr = 1'b1;
      cyc('0, {tag, ".t4_clr"});
      clr = 1'b0;
      cyc('0, {tag, ".after_clr"});
      return;
    end
    cyc(busy_rec(bit_of(18), bit_of(int'(rb)), 1'b0, 1'b0, alu, 1'b0, 1'b0), {tag, ".t4"});
    cyc(busy_rec(bit_of(17), bit_of(19), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), {tag, ".t5"});
    start = start_at_end;
    cyc(busy_rec(bit_of(16), bit_of(18), 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), {tag, ".t6"});
    start = 1'b0;
    cyc('0, {tag, ".after_done"});
  endtask

  initial begin
    logic [31:0] rir;
    logic [4:0]  ropc;
    int          sel;

    clr = 1'b1; start = 1'b1; mem_ready = 1'b1; ir = 32'h78900000;
    @(posedge clk); #1;
    cyc('0, "reset_c1");
    cyc('0, "reset_c2");
    clr = 1'b0; start = 1'b0;
    cyc('0, "idle_after_reset");

    run_instr(32'h78900000, 0, 1'b0, 1'b0, "mul_r1_r2");
    run_instr(32'h81A00000, 0, 1'b0, 1'b0, "div_r3_r4");
    run_instr(32'h78900000, 3, 1'b0, 1'b0, "mul_wait3");
    run_instr(32'h10000000, 0, 1'b0, 1'b1, "illegal_op");
    run_instr(32'h81A00000, 1, 1'b1, 1'b0, "clr_in_t4");
    run_instr(32'h81A00000, 0, 1'b0, 1'b1, "div_after_clr");
    run_instr({OPC_MUL, 4'd5, 4'd5, 19'd0}, 0, 1'b0, 1'b0, "ra_eq_rb");
    run_instr({OPC_DIV, 4'd0, 4'd15, 19'h7FFFF}, 0, 1'b0, 1'b0, "r0_r15");

`ifdef MULDIV_SEQ_TIMEOUT_EN
    start = 1'b1; ir = 32'h78900000; mem_ready = 1'b0;
    cyc('0, "to.idle_start");
    start = 1'b0;
    cyc(busy_rec(bit_of(25) | bit_of(18), bit_of(20), 1'b0, 1'b1, 4'd0, 1'b0, 1'b0), "to.t0");
    for (int i = 0; i < TIMEOUT - 1; i++) cyc(t1_rec(1'b0, 1'b0), $sformatf("to.t1_wait%0d", i));
    cyc(t1_rec(1'b0, 1'b1), "to.t1_expire");
    cyc('0, "to.after_expire");
`endif

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 4);
      if (sel < 2)       ropc = OPC_MUL;
      else if (sel < 4)  ropc = OPC_DIV;
      else begin
        ropc = 5'($urandom);
        if (ropc == OPC_MUL || ropc == OPC_DIV) ropc = 5'b00010;
      end
      rir = {ropc, 27'($urandom)};
      run_instr(rir, $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
